// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch front end and the decoders
// that consume its output:
//   - fetch FSM state encoding
//   - the canonical NOP (addi x0, x0, 0) loaded into the instruction register
//   - RV32 instruction field bit positions
//   - a small alignment helper used by the next-PC logic
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // RV32 base-format field positions, shared with the controller's decoders.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  // Word alignment: the core has no compressed instructions, so any target
  // with either of the two low bits set is illegal.
  function automatic logic pc_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC selection for the fetch unit.
//   pc         in  32  address of the current instruction
//   pcsrc      in  1   1 selects pc_target, 0 selects pc + 4
//   pc_target  in  32  branch/jump target from the datapath
//   pc_plus4   out 32  pc + 4, wrapping modulo 2^32
//   next_pc    out 32  selected next PC
//   misaligned out 1   next_pc is not word aligned
// Kept separate so the jalr target path can be folded in later.
// ---------------------------------------------------------------------------
module pc_next_sel
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pcsrc,
  input  logic [31:0] pc_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  // 32-bit result: the carry out of 0xFFFF_FFFC + 4 is dropped, giving 0.
  assign pc_plus4   = pc + 32'd4;
  assign next_pc    = pcsrc ? pc_target : pc_plus4;
  assign misaligned = !pc_aligned(next_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Front-end stage of the RISC-V core. Holds the PC, fetches one instruction
// at a time over a valid/ready request with a variable-latency response,
// and presents the instruction plus its decoded fields to the controller.
// No prefetch, no speculation: exactly one instruction in flight.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request (addr always equals pc)
//   imem_ready               request accepted when imem_req && imem_ready
//   imem_rvalid/imem_rdata   instruction response
//   PCsrc, pc_target         next-PC decision, sampled on accept
//   instr_accept             core has executed the presented instruction
//   instr_valid, instr       presented instruction
//   opcode..rs2              decoded fields (pure slices of instr)
//   pc, pc_plus4             address of presented instruction and pc + 4
//   fault                    sticky misaligned-target flag
//   retired                  count of accepted instructions (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        PCsrc,
  input  logic [31:0] pc_target,
  input  logic        instr_accept,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault,
  output logic [31:0] retired
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  retired_reg;
  logic         fault_reg;

  logic [31:0]  next_pc;
  logic         next_misaligned;
  logic         accept_fire;
  logic         resp_fire;

  pc_next_sel u_pc_next_sel (
    .pc         (pc_reg),
    .pcsrc      (PCsrc),
    .pc_target  (pc_target),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (next_misaligned)
  );

  // Responses and accepts only count in the state that expects them.
  assign resp_fire   = (state_reg == S_WAIT) && imem_rvalid;
  assign accept_fire = (state_reg == S_HOLD) && instr_accept;

  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_reg)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_accept) begin
          state_next = next_misaligned ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
    // Outputs are suppressed combinationally while rst is held so that no
    // request or instruction is ever shown in a reset cycle.
    if (rst) begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_REQ;
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP_INSTR;
      retired_reg <= 32'd0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (resp_fire) begin
        instr_reg <= imem_rdata;
      end
      if (accept_fire) begin
        retired_reg <= retired_reg + 32'd1;
        // A misaligned target leaves pc pointing at the offending
        // instruction so the fault can be attributed.
        if (next_misaligned) begin
          fault_reg <= 1'b1;
        end else begin
          pc_reg <= next_pc;
        end
      end
    end
  end

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign instr     = instr_reg;
  assign fault     = fault_reg;
  assign retired   = retired_reg;

  assign opcode = instr_reg[OPCODE_MSB:OPCODE_LSB];
  assign rd     = instr_reg[RD_MSB:RD_LSB];
  assign funct3 = instr_reg[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1    = instr_reg[RS1_MSB:RS1_LSB];
  assign rs2    = instr_reg[RS2_MSB:RS2_LSB];
  assign funct7 = instr_reg[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. A main instance runs the fetch
// scenarios in sequence; a second instance with RESET_PC = 0xFFFF_FFFC
// exercises the pc + 4 wrap at the top of the address space.
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        PCsrc;
  logic [31:0] pc_target;
  logic        instr_accept;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] retired;

  // Second instance for the wrap scenario.
  logic        w_rst;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ready;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_pcsrc;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_fault;
  logic [31:0] w_retired;

  int checks;
  int failures;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .PCsrc        (PCsrc),
    .pc_target    (pc_target),
    .instr_accept (instr_accept),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fault        (fault),
    .retired      (retired)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk          (clk),
    .rst          (w_rst),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ready   (w_ready),
    .imem_rvalid  (w_rvalid),
    .imem_rdata   (w_rdata),
    .PCsrc        (w_pcsrc),
    .pc_target    (w_target),
    .instr_accept (w_accept),
    .instr_valid  (w_valid),
    .instr        (w_instr),
    .opcode       (w_opcode),
    .funct3       (w_funct3),
    .funct7       (w_funct7),
    .rd           (w_rd),
    .rs1          (w_rs1),
    .rs2          (w_rs2),
    .pc           (w_pc),
    .pc_plus4     (w_pc_plus4),
    .fault        (w_fault),
    .retired      (w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
        failures++;
        $display("FAIL reset_req cycle %0d: got %b expected 0", i, imem_req);
      end
      checks++;
      if (instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid cycle %0d: got %b expected 0", i, instr_valid);
      end
      checks++;
      if (instr !== 32'h0000_0013) begin
        failures++;
        $display("FAIL reset_instr cycle %0d: got %h expected 00000013", i, instr);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000",
               imem_req, imem_addr);
    end
    $display("test_reset done: req=%b addr=%h", imem_req, imem_addr);
  endtask

  task automatic test_zero_wait();
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_addr;
    imem_ready   = 1'b1;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h0010_0093;
    instr_accept = 1'b1;
    PCsrc        = 1'b0;
    pc_target    = 32'h0;
    for (int k = 0; k < 12; k++) begin
      #1;
      exp_req   = (k % 3 == 0);
      exp_valid = (k % 3 == 2);
      exp_addr  = 32'(4 * (k / 3));
      checks++;
      if (imem_req !== exp_req || instr_valid !== exp_valid) begin
        failures++;
        $display("FAIL zero_wait_ctl cycle %0d: got req=%b valid=%b expected req=%b valid=%b",
                 k, imem_req, instr_valid, exp_req, exp_valid);
      end
      checks++;
      if (imem_addr !== exp_addr) begin
        failures++;
        $display("FAIL zero_wait_addr cycle %0d: got %h expected %h", k, imem_addr, exp_addr);
      end
      tick();
    end
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    instr_accept = 1'b0;
    #1;
    checks++;
    if (retired !== 32'd4) begin
      failures++;
      $display("FAIL zero_wait_retired: got %0d expected 4", retired);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL zero_wait_next: got req=%b addr=%h expected req=1 addr=00000010",
               imem_req, imem_addr);
    end
    $display("test_zero_wait done: retired=%0d addr=%h", retired, imem_addr);
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
        failures++;
        $display("FAIL bp_stall cycle %0d: got req=%b addr=%h expected req=1 addr=00000010",
                 i, imem_req, imem_addr);
      end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL bp_handshake: got req=%b addr=%h expected req=1 addr=00000010",
               imem_req, imem_addr);
    end
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_wait cycle %0d: got req=%b valid=%b expected req=0 valid=0",
                 i, imem_req, instr_valid);
      end
      tick();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A3_0663;
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_rvalid_cycle: got valid=%b expected 0", instr_valid);
    end
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h00A3_0663) begin
      failures++;
      $display("FAIL bp_valid: got valid=%b instr=%h expected valid=1 instr=00a30663",
               instr_valid, instr);
    end
    $display("test_back_pressure done: valid=%b instr=%h", instr_valid, instr);
  endtask

  task automatic test_taken_branch();
    checks++;
    if (opcode !== 7'h63 || funct3 !== 3'd0 || rs1 !== 5'd6 || rs2 !== 5'd10 ||
        rd !== 5'd12 || funct7 !== 7'd0) begin
      failures++;
      $display("FAIL branch_fields: got op=%h f3=%0d rs1=%0d rs2=%0d rd=%0d f7=%0d expected op=63 f3=0 rs1=6 rs2=10 rd=12 f7=0",
               opcode, funct3, rs1, rs2, rd, funct7);
    end
    checks++;
    if (pc !== 32'h10 || pc_plus4 !== 32'h14) begin
      failures++;
      $display("FAIL branch_pc: got pc=%h pc_plus4=%h expected 00000010 00000014", pc, pc_plus4);
    end
    instr_accept = 1'b1;
    PCsrc        = 1'b1;
    pc_target    = 32'h1C;
    tick();
    instr_accept = 1'b0;
    PCsrc        = 1'b0;
    pc_target    = 32'h0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1C) begin
      failures++;
      $display("FAIL branch_target: got req=%b addr=%h expected req=1 addr=0000001c",
               imem_req, imem_addr);
    end
    checks++;
    if (retired !== 32'd5 || fault !== 1'b0) begin
      failures++;
      $display("FAIL branch_state: got retired=%0d fault=%b expected 5 0", retired, fault);
    end
    $display("test_taken_branch done: addr=%h retired=%0d", imem_addr, retired);
  endtask

  task automatic test_misaligned();
    imem_ready = 1'b1;
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_006F;
    tick();
    imem_rvalid = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_006F) begin
      failures++;
      $display("FAIL mis_fetch: got valid=%b instr=%h expected 1 0000006f", instr_valid, instr);
    end
    instr_accept = 1'b1;
    PCsrc        = 1'b1;
    pc_target    = 32'h22;
    tick();
    // Leave every handshake input active: HALT must ignore them all.
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b1 || pc !== 32'h1C || instr_valid !== 1'b0 || retired !== 32'd6) begin
      failures++;
      $display("FAIL mis_enter: got fault=%b pc=%h valid=%b retired=%0d expected 1 0000001c 0 6",
               fault, pc, instr_valid, retired);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL mis_halt cycle %0d: got req=%b valid=%b expected 0 0", i, imem_req, instr_valid);
      end
      tick();
      #1;
    end
    checks++;
    if (pc !== 32'h1C || fault !== 1'b1 || retired !== 32'd6) begin
      failures++;
      $display("FAIL mis_hold: got pc=%h fault=%b retired=%0d expected 0000001c 1 6", pc, fault, retired);
    end
    rst = 1'b1;
    tick();
    #1;
    checks++;
    if (fault !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL mis_rst: got fault=%b req=%b expected 0 0", fault, imem_req);
    end
    rst          = 1'b0;
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    instr_accept = 1'b0;
    PCsrc        = 1'b0;
    pc_target    = 32'h0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || retired !== 32'd0) begin
      failures++;
      $display("FAIL mis_refetch: got req=%b addr=%h retired=%0d expected 1 00000000 0",
               imem_req, imem_addr, retired);
    end
    $display("test_misaligned done: fault=%b addr=%h", fault, imem_addr);
  endtask

  task automatic test_mid_reset();
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL midrst_wait: got req=%b expected 0", imem_req);
    end
    // Response arrives in the same cycle as reset: reset must win.
    rst         = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    rst         = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL midrst_req: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
    checks++;
    if (instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_instr: got instr=%h valid=%b expected 00000013 0", instr, instr_valid);
    end
    tick();
    #1;
    checks++;
    if (imem_req !== 1'b1 || instr !== 32'h0000_0013) begin
      failures++;
      $display("FAIL midrst_hold: got req=%b instr=%h expected 1 00000013", imem_req, instr);
    end
    $display("test_mid_reset done: req=%b addr=%h", imem_req, imem_addr);
  endtask

  task automatic test_wrap();
    w_rst = 1'b0;
    #1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_first: got req=%b addr=%h expected 1 fffffffc", w_req, w_addr);
    end
    w_ready = 1'b1;
    tick();
    w_ready  = 1'b0;
    w_rvalid = 1'b1;
    tick();
    w_rvalid = 1'b0;
    #1;
    checks++;
    if (w_valid !== 1'b1 || w_pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_plus4: got valid=%b pc_plus4=%h expected 1 00000000", w_valid, w_pc_plus4);
    end
    w_accept = 1'b1;
    tick();
    w_accept = 1'b0;
    #1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'h0 || w_fault !== 1'b0 || w_retired !== 32'd1) begin
      failures++;
      $display("FAIL wrap_next: got req=%b addr=%h fault=%b retired=%0d expected 1 00000000 0 1",
               w_req, w_addr, w_fault, w_retired);
    end
    $display("test_wrap done: addr=%h fault=%b", w_addr, w_fault);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    PCsrc        = 1'b0;
    pc_target    = 32'h0;
    instr_accept = 1'b0;
    w_rst        = 1'b1;
    w_ready      = 1'b0;
    w_rvalid     = 1'b0;
    w_rdata      = 32'h0000_0013;
    w_pcsrc      = 1'b0;
    w_target     = 32'h0;
    w_accept     = 1'b0;

    test_reset();
    test_zero_wait();
    test_back_pressure();
    test_taken_branch();
    test_misaligned();
    test_mid_reset();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
